// File: rtl/mem_access_sequencer_pkg.sv
// Shared encodings for the memory access sequencer: size codes, FSM states, RW polarity
// and small request-decode helpers.
package mem_access_sequencer_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // RW polarity as encoded in the control unit microstore
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef logic [1:0] mas_size_t;

    typedef struct packed {
        logic [31:0] wdata;
        mas_size_t   size;
        logic        rw;
        logic        sext;
    } mas_req_t;

    function automatic logic [2:0] num_bytes(input mas_size_t sz);
        case (sz)
            SZ_BYTE: num_bytes = 3'd1;
            SZ_HALF: num_bytes = 3'd2;
            default: num_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic is_reject(input mas_size_t sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: is_reject = 1'b0;
            SZ_HALF: is_reject = a[0];
            SZ_WORD: is_reject = |a;
            default: is_reject = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mas_byte_assembler.sv
// Byte datapath: big-endian write lane select, MSB-first read shift register and
// zero/sign extension of the word being completed by the incoming byte.
module mas_byte_assembler
    import mem_access_sequencer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    input  mas_size_t   ext_size_i,
    input  logic        sext_i,
    output logic [31:0] ext_word_o,
    input  logic [31:0] lane_wdata_i,
    input  mas_size_t   lane_size_i,
    input  logic [1:0]  lane_k_i,
    output logic [7:0]  lane_byte_o
);

    logic [23:0] shift_q, shift_d;
    logic [31:0] assembled;
    logic [2:0]  nbytes;
    logic [1:0]  lane;

    always_comb begin
        shift_d = shift_q;
        if (clear_i) begin
            shift_d = '0;
        end else if (shift_en_i) begin
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    // Extension sees the byte being sampled this edge, so rdata can load in the same cycle
    always_comb begin
        assembled  = {shift_q, byte_i};
        ext_word_o = assembled;
        case (ext_size_i)
            SZ_BYTE: ext_word_o = {{24{sext_i & assembled[7]}}, assembled[7:0]};
            SZ_HALF: ext_word_o = {{16{sext_i & assembled[15]}}, assembled[15:0]};
            default: ext_word_o = assembled;
        endcase
    end

    always_comb begin
        nbytes = num_bytes(lane_size_i);
        lane   = 2'(nbytes - 3'd1 - {1'b0, lane_k_i});
        case (lane)
            2'd0:    lane_byte_o = lane_wdata_i[7:0];
            2'd1:    lane_byte_o = lane_wdata_i[15:8];
            2'd2:    lane_byte_o = lane_wdata_i[23:16];
            default: lane_byte_o = lane_wdata_i[31:24];
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences one MOV/MOC memory request into big-endian byte accesses on a byte-wide RAM,
// returning the assembled read word and the misalignment verdict.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              MOC,
    output logic              misalign,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_en,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    localparam int unsigned WaitW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [ADDR_W-1:0] base_q, base_d;
    mas_req_t          req_q, req_d;
    logic              moc_q, moc_d;
    logic              mis_q, mis_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;

    logic              asm_clear, asm_shift;
    logic [31:0]       ext_word;
    logic [31:0]       lane_wdata;
    mas_size_t         lane_size;
    logic [1:0]        lane_k;
    logic [7:0]        lane_byte;
    logic [1:0]        k_last;
    logic              unused_addr_bits;

    // Upper address bits alias onto the RAM
    assign unused_addr_bits = ^addr[31:ADDR_W];

    assign k_last = 2'(num_bytes(req_q.size) - 3'd1);

    // In IDLE the first lane comes straight from the request; afterwards from the latch
    always_comb begin
        if (state_q == S_IDLE) begin
            lane_wdata = wdata;
            lane_size  = size;
            lane_k     = 2'd0;
        end else begin
            lane_wdata = req_q.wdata;
            lane_size  = req_q.size;
            lane_k     = k_q + 2'd1;
        end
    end

    mas_byte_assembler u_asm (
        .clk_i        (clk),
        .rst_ni       (reset),
        .clear_i      (asm_clear),
        .shift_en_i   (asm_shift),
        .byte_i       (ram_rdata),
        .ext_size_i   (req_q.size),
        .sext_i       (req_q.sext),
        .ext_word_o   (ext_word),
        .lane_wdata_i (lane_wdata),
        .lane_size_i  (lane_size),
        .lane_k_i     (lane_k),
        .lane_byte_o  (lane_byte)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wait_d      = wait_q;
        base_d      = base_q;
        req_d       = req_q;
        moc_d       = moc_q;
        mis_d       = mis_q;
        rdata_d     = rdata_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        asm_clear   = 1'b0;
        asm_shift   = 1'b0;

        case (state_q)
            S_IDLE: begin
                moc_d = 1'b0;
                mis_d = 1'b0;
                if (MOV) begin
                    base_d     = addr[ADDR_W-1:0];
                    req_d.wdata = wdata;
                    req_d.size = size;
                    req_d.rw   = RW;
                    req_d.sext = sign_ext;
                    if (is_reject(size, addr[1:0])) begin
                        state_d = S_DONE;
                        moc_d   = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        k_d         = 2'd0;
                        wait_d      = '0;
                        asm_clear   = 1'b1;
                        ram_en_d    = 1'b1;
                        ram_we_d    = (RW == RW_WRITE);
                        ram_addr_d  = addr[ADDR_W-1:0];
                        ram_wdata_d = lane_byte;
                    end
                end
            end
            S_ACCESS: begin
                if (wait_q == WaitLast) begin
                    wait_d    = '0;
                    asm_shift = (req_q.rw == RW_READ);
                    if (k_q == k_last) begin
                        state_d  = S_DONE;
                        moc_d    = 1'b1;
                        mis_d    = 1'b0;
                        ram_en_d = 1'b0;
                        ram_we_d = 1'b0;
                        if (req_q.rw == RW_READ) begin
                            rdata_d = ext_word;
                        end
                    end else begin
                        k_d         = k_q + 2'd1;
                        ram_addr_d  = base_q + ADDR_W'(k_q + 2'd1);
                        ram_wdata_d = lane_byte;
                    end
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            S_DONE: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                    moc_d   = 1'b0;
                    mis_d   = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                moc_d    = 1'b0;
                mis_d    = 1'b0;
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            wait_q      <= '0;
            base_q      <= '0;
            req_q       <= '0;
            moc_q       <= 1'b0;
            mis_q       <= 1'b0;
            rdata_q     <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wait_q      <= wait_d;
            base_q      <= base_d;
            req_q       <= req_d;
            moc_q       <= moc_d;
            mis_q       <= mis_d;
            rdata_q     <= rdata_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign MOC       = moc_q;
    assign misalign  = mis_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench: one sequencer with WAIT_CYCLES=1 and one with WAIT_CYCLES=3, each on its own
// byte RAM model.
module tb_mem_access_sequencer;
    import mem_access_sequencer_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, MOV, MOV3, RW, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, rdata3;
    logic        MOC, MOC3, misalign, misalign3;
    logic [8:0]  ram_addr, ram_addr3;
    logic [7:0]  ram_wdata, ram_wdata3, ram_rdata, ram_rdata3;
    logic        ram_en, ram_en3, ram_we, ram_we3;

    logic [7:0]  mem  [512] = '{default: 8'h00};
    logic [7:0]  mem3 [512] = '{18: 8'hBE, 19: 8'hEF, default: 8'h00};

    assign ram_rdata  = mem[ram_addr];
    assign ram_rdata3 = mem3[ram_addr3];

    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en3 && ram_we3) mem3[ram_addr3] <= ram_wdata3;
    end

    mem_access_sequencer #(.ADDR_W(9), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .MOC(MOC), .misalign(misalign),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    mem_access_sequencer #(.ADDR_W(9), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .MOV(MOV3), .RW(RW), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .MOC(MOC3), .misalign(misalign3),
        .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_en(ram_en3), .ram_we(ram_we3),
        .ram_rdata(ram_rdata3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic rw_v, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        RW = rw_v; size = sz; sign_ext = sx; addr = a; wdata = wd; MOV = 1'b1;
    endtask

    // Counts edges from E0 until MOC is seen, plus ram_en/ram_we cycles before that
    task automatic wait_moc(output int edges, output int en_c, output int we_c);
        bit seen;
        seen = 1'b0; edges = 0; en_c = 0; we_c = 0;
        while (!seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (MOC) seen = 1'b1;
            else begin
                en_c += int'(ram_en);
                we_c += int'(ram_we);
            end
        end
    endtask

    task automatic end_hs(input string tag);
        MOV = 1'b0;
        @(posedge clk); #1;
        chk(tag, 32'(MOC), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, en, we;
        bit done;
        logic [8:0] a3 [6];

        reset = 1'b1; MOV = 1'b0; MOV3 = 1'b0; RW = 1'b1; size = SZ_BYTE; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_moc", 32'(MOC), 0);
        chk("rst_mis", 32'(misalign), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_en", 32'(ram_en), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_wdata", 32'(ram_wdata), 0);
        @(posedge clk); #1 reset = 1'b1;

        // Word write
        start(RW_WRITE, SZ_WORD, 1'b0, 32'h010, 32'hDEADBEEF);
        wait_moc(e, en, we);
        chk("ww_edges", e, 5);
        chk("ww_en", en, 4);
        chk("ww_we", we, 4);
        chk("ww_rdata", rdata, 0);
        chk("ww_mis", 32'(misalign), 0);
        end_hs("ww_mocfall");
        chk("ww_m10", 32'(mem[9'h010]), 32'hDE);
        chk("ww_m11", 32'(mem[9'h011]), 32'hAD);
        chk("ww_m12", 32'(mem[9'h012]), 32'hBE);
        chk("ww_m13", 32'(mem[9'h013]), 32'hEF);

        // Word read
        start(RW_READ, SZ_WORD, 1'b0, 32'h010, 32'h0);
        wait_moc(e, en, we);
        chk("wr_edges", e, 5);
        chk("wr_we", we, 0);
        chk("wr_rdata", rdata, 32'hDEADBEEF);
        end_hs("wr_mocfall");

        // Halfword read, sign-extended
        start(RW_READ, SZ_HALF, 1'b1, 32'h012, 32'h0);
        wait_moc(e, en, we);
        chk("hr_edges", e, 3);
        chk("hr_rdata", rdata, 32'hFFFFBEEF);
        end_hs("hr_mocfall");

        // Byte read, sign-extended, then MOV held past MOC
        start(RW_READ, SZ_BYTE, 1'b1, 32'h013, 32'h0);
        wait_moc(e, en, we);
        chk("brs_edges", e, 2);
        chk("brs_en", en, 1);
        chk("brs_rdata", rdata, 32'hFFFFFFEF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_moc", 32'(MOC), 1);
            chk("hold_en", 32'(ram_en), 0);
        end
        end_hs("hold_mocfall");

        // Byte read, zero-extended
        start(RW_READ, SZ_BYTE, 1'b0, 32'h013, 32'h0);
        wait_moc(e, en, we);
        chk("brz_edges", e, 2);
        chk("brz_rdata", rdata, 32'h000000EF);
        end_hs("brz_mocfall");

        // Misaligned word read
        start(RW_READ, SZ_WORD, 1'b0, 32'h011, 32'h0);
        wait_moc(e, en, we);
        chk("mis_edges", e, 1);
        chk("mis_flag", 32'(misalign), 1);
        chk("mis_en", en, 0);
        chk("mis_rdata", rdata, 32'h000000EF);
        end_hs("mis_mocfall");
        chk("mis_clear", 32'(misalign), 0);

        // Illegal size
        start(RW_READ, SZ_BAD, 1'b0, 32'h010, 32'h0);
        wait_moc(e, en, we);
        chk("bad_edges", e, 1);
        chk("bad_flag", 32'(misalign), 1);
        chk("bad_en", en, 0);
        chk("bad_rdata", rdata, 32'h000000EF);
        end_hs("bad_mocfall");

        // MOV dropped right after E0: access completes, single-cycle MOC
        start(RW_READ, SZ_WORD, 1'b0, 32'h010, 32'h0);
        @(posedge clk); #1;
        MOV = 1'b0;
        e = 0; done = 1'b0;
        while (!done && e < 20) begin
            @(posedge clk); #1;
            e++;
            if (MOC) done = 1'b1;
        end
        chk("drop_edges", e, 4);
        chk("drop_rdata", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("drop_pulse", 32'(MOC), 0);

        // Reset after byte 1 of a word write to 0x020
        start(RW_WRITE, SZ_WORD, 1'b0, 32'h020, 32'h11223344);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; MOV = 1'b0;
        #1;
        chk("mrst_moc", 32'(MOC), 0);
        chk("mrst_rdata", rdata, 0);
        chk("mrst_en", 32'(ram_en), 0);
        chk("mrst_we", 32'(ram_we), 0);
        chk("mrst_addr", 32'(ram_addr), 0);
        chk("mrst_wdata", 32'(ram_wdata), 0);
        @(posedge clk); #1 reset = 1'b1;
        chk("mrst_m20", 32'(mem[9'h020]), 32'h11);
        chk("mrst_m21", 32'(mem[9'h021]), 32'h22);
        chk("mrst_m22", 32'(mem[9'h022]), 32'h00);
        chk("mrst_m23", 32'(mem[9'h023]), 32'h00);

        start(RW_READ, SZ_BYTE, 1'b0, 32'h021, 32'h0);
        wait_moc(e, en, we);
        chk("post_edges", e, 2);
        chk("post_rdata", rdata, 32'h00000022);
        end_hs("post_mocfall");

        // Upper address bits alias onto the 512-byte RAM
        start(RW_READ, SZ_BYTE, 1'b0, 32'h0000_0213, 32'h0);
        wait_moc(e, en, we);
        chk("alias_rdata", rdata, 32'h000000EF);
        end_hs("alias_mocfall");

        // WAIT_CYCLES=3 halfword read
        RW = RW_READ; size = SZ_HALF; sign_ext = 1'b0; addr = 32'h012; wdata = '0;
        MOV3 = 1'b1;
        e = 0; done = 1'b0;
        while (!done && e < 40) begin
            @(posedge clk); #1;
            e++;
            if (MOC3) done = 1'b1;
            else if (e <= 6) a3[e-1] = ram_addr3;
        end
        chk("w3_edges", e, 7);
        chk("w3_a0", 32'(a3[0]), 32'h12);
        chk("w3_a1", 32'(a3[1]), 32'h12);
        chk("w3_a2", 32'(a3[2]), 32'h12);
        chk("w3_a3", 32'(a3[3]), 32'h13);
        chk("w3_a4", 32'(a3[4]), 32'h13);
        chk("w3_a5", 32'(a3[5]), 32'h13);
        chk("w3_rdata", rdata3, 32'h0000BEEF);
        MOV3 = 1'b0;
        @(posedge clk); #1;
        chk("w3_mocfall", 32'(MOC3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Memory interface stage downstream of the microprogrammed control unit. It consumes the control unit's memory request (MOV, RW, access size, MAR address, MDR data) and performs the access on a byte-wide synchronous-write RAM, one byte at a time in big-endian order. It returns the assembled, optionally sign-extended read word for the MDR, and raises MOC to complete a four-phase handshake. The control unit waits on MOC in its condition mux.

## Interface
Parameters:
- ADDR_W, 9: RAM address width (512 bytes); upper address bits ignored (aliasing)
- WAIT_CYCLES, 1: cycles per byte access, ≥1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- MOV  in  1  memory operation valid (request)
- RW  in  1  1 = read, 0 = write
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  in  1  read only: sign-extend byte/halfword
- addr  in  32  byte address from MAR
- wdata  in  32  write data from MDR
- rdata  out  32  registered read result to MDR
- MOC  out  1  memory operation complete
- misalign  out  1  access rejected (misaligned or size 11); valid while MOC=1
- ram_addr  out  ADDR_W  byte address to RAM
- ram_wdata  out  8  byte to RAM
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable (only with ram_en)
- ram_rdata  in  8  RAM read byte, combinational from ram_addr

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: MOC=0, misalign=0, ram_en=0. When MOV=1 at an edge, latch addr, size, RW, wdata, sign_ext.
  - Reject when size=11, halfword with addr[0]≠0, or word with addr[1:0]≠0. A rejected request goes to DONE with misalign=1 and makes no RAM access.
  - Otherwise go to ACCESS with byte index k=0 and N = 1, 2 or 4.
- ACCESS: byte k drives ram_addr = base+k (mod 2^ADDR_W) and ram_en=1 for WAIT_CYCLES cycles. ram_we=!RW during those cycles.
  - Write byte order (big-endian): word uses wdata[31-8k -: 8]; halfword uses wdata[15:8], then [7:0]; byte uses wdata[7:0].
  - Read: ram_rdata is sampled at the edge ending byte k's last wait cycle and shifted into an assembly register (MSB first).
  - After byte N-1, go to DONE.
- On entering DONE, a read loads rdata:
  - word: assembled value.
  - halfword/byte: zero- or sign-extended per sign_ext.
  - Writes and rejected requests leave rdata unchanged.
- DONE: MOC=1; misalign holds the verdict. Stays while MOV=1. MOV=0 at an edge returns to IDLE.
- New requests are accepted only in IDLE. MOV held high in DONE does not start a second access.
- If MOV drops during ACCESS (protocol violation), the access still completes. DONE lasts one cycle, so MOC pulses once.
- Reset asserted (any state): immediately IDLE, MOC=0, misalign=0, rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0. Bytes already written stay written.

## Timing
- MOV is sampled at edge E0.
- Valid access: MOC rises after edge E0+N·WAIT_CYCLES+1. With WAIT_CYCLES=1: byte 2, halfword 3, word 5 edges.
- Rejected request: MOC rises after E0+1.
- MOC falls one edge after MOV is sampled low. The earliest next request is sampled in the following IDLE cycle.
- rdata is valid from the cycle MOC rises and is stable until the next completed read.
- ram_* outputs are registered and glitch-free. ram_we is never high without ram_en.

## Structure
- Shared package:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - state encoding: S_IDLE, S_ACCESS, S_DONE.
  - RW polarity constants, shared with the control unit microstore.
- One sub-module, mas_byte_assembler: shift-in register, byte-lane select for write data, extension logic. The top level holds the FSM, byte counter k and wait counter.

## Test plan
- Word write 0xDEADBEEF to addr 0x010, W=1 → RAM[0x10..0x13]=DE,AD,BE,EF; ram_we high 4 cycles; MOC high after 5 edges; rdata unchanged.
- Byte read 0x013 (holding 0xEF): sign_ext=1 → rdata 0xFFFFFFEF; sign_ext=0 → 0x000000EF; MOC after 2 edges.
- Halfword read 0x012, WAIT_CYCLES=3 → rdata 0x0000BEEF; each address held 3 cycles; MOC after 7 edges.
- Word read 0x011, and separately size=11 → misalign=1, MOC after 1 edge, ram_en never high, rdata unchanged.
- reset driven low after the byte-1 write of a word write to 0x020 → all outputs at reset values immediately; only 0x020 and 0x021 modified. A subsequent request completes normally.
- Handshake: MOV held high 3 cycles past MOC → MOC stays 1, no new ram_en. MOV low → MOC 0 after the next edge. MOV dropped mid-ACCESS → single-cycle MOC pulse.
